// File: rtl/alu_operand_sequencer_if.sv
//------------------------------------------------------------------------------
// alu_operand_sequencer_if : request, RAM, ALU and PSW signals of the sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_operand_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_alu_op;
   logic [1:0] req_mode;
   logic [7:0] req_operand;
   logic [1:0] rs;
   logic       acc_wr_en;
   logic [7:0] acc_wr_data;
   logic       ram_rd;
   logic [7:0] ram_addr;
   logic [7:0] ram_rdata;
   logic [2:0] alu_opcode;
   logic [7:0] alu_op1;
   logic [7:0] alu_op2;
   logic       alu_carry_in;
   logic [7:0] alu_result;
   logic       alu_cy;
   logic       alu_ac;
   logic       alu_ov;
   logic [7:0] acc_out;
   logic       psw_cy;
   logic       psw_ac;
   logic       psw_ov;
   logic       psw_p;
   logic       done;

   modport slave (
      input  req_valid, req_alu_op, req_mode, req_operand, rs,
      input  acc_wr_en, acc_wr_data, ram_rdata,
      input  alu_result, alu_cy, alu_ac, alu_ov,
      output req_ready, ram_rd, ram_addr,
      output alu_opcode, alu_op1, alu_op2, alu_carry_in,
      output acc_out, psw_cy, psw_ac, psw_ov, psw_p, done
   );

   modport master (
      output req_valid, req_alu_op, req_mode, req_operand, rs,
      output acc_wr_en, acc_wr_data, ram_rdata,
      output alu_result, alu_cy, alu_ac, alu_ov,
      input  req_ready, ram_rd, ram_addr,
      input  alu_opcode, alu_op1, alu_op2, alu_carry_in,
      input  acc_out, psw_cy, psw_ac, psw_ov, psw_p, done
   );
endinterface

`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
//------------------------------------------------------------------------------
// alu_operand_sequencer : fetches op2, drives the ALU, owns ACC and CY/AC/OV/P
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_operand_sequencer (
   input  wire logic               clock,
   input  wire logic               reset,
   alu_operand_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_PTR  = 3'd1,
      S_CAP_PTR = 3'd2,
      S_RD_OP   = 3'd3,
      S_CAP_OP  = 3'd4,
      S_EXEC    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam logic [2:0] c_OP_ADD  = 3'b010;
   localparam logic [2:0] c_OP_ADDC = 3'b011;
   localparam logic [2:0] c_OP_SUBB = 3'b100;

   state_t     r_state;
   state_t     w_next;
   logic       w_ram_rd;
   logic       w_ready;
   logic       w_accept;
   logic       w_incdec;
   logic       w_arith;
   logic [7:0] w_req_addr;

   logic [2:0] r_op;
   logic [7:0] r_addr;
   logic [7:0] r_op2;
   logic [7:0] r_acc;
   logic       r_cy;
   logic       r_ac;
   logic       r_ov;
   logic [7:0] r_ram_addr_hold;
   logic [2:0] r_alu_opcode_hold;
   logic [7:0] r_alu_op1_hold;
   logic [7:0] r_alu_op2_hold;
   logic       r_alu_cin_hold;

   assign w_ready  = (r_state == S_IDLE) && !reset;
   assign w_accept = bus.req_valid && w_ready;
   assign w_incdec = (bus.req_alu_op[2:1] == 2'b00);
   assign w_arith  = (r_op == c_OP_ADD) || (r_op == c_OP_ADDC) || (r_op == c_OP_SUBB);

   // For @Ri this is the pointer register; it is replaced by the fetched pointer.
   always_comb begin
      w_req_addr = bus.req_operand;
      case (bus.req_mode)
         2'b10:   w_req_addr = {3'b000, bus.rs, bus.req_operand[2:0]};
         2'b11:   w_req_addr = {3'b000, bus.rs, 2'b00, bus.req_operand[0]};
         default: w_req_addr = bus.req_operand;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_ram_rd = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_incdec || bus.req_mode == 2'b00) w_next = S_EXEC;
               else if (bus.req_mode == 2'b11)        w_next = S_RD_PTR;
               else                                   w_next = S_RD_OP;
            end
         end
         S_RD_PTR: begin
            w_ram_rd = 1'b1;
            w_next   = S_CAP_PTR;
         end
         S_CAP_PTR: w_next = S_RD_OP;
         S_RD_OP: begin
            w_ram_rd = 1'b1;
            w_next   = S_CAP_OP;
         end
         S_CAP_OP:  w_next = S_EXEC;
         S_EXEC:    w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_op              <= 3'b000;
         r_addr            <= 8'h00;
         r_op2             <= 8'h00;
         r_acc             <= 8'h00;
         r_cy              <= 1'b0;
         r_ac              <= 1'b0;
         r_ov              <= 1'b0;
         r_ram_addr_hold   <= 8'h00;
         r_alu_opcode_hold <= 3'b000;
         r_alu_op1_hold    <= 8'h00;
         r_alu_op2_hold    <= 8'h00;
         r_alu_cin_hold    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.acc_wr_en) r_acc <= bus.acc_wr_data;
               if (w_accept) begin
                  r_op   <= bus.req_alu_op;
                  r_addr <= w_req_addr;
                  r_op2  <= bus.req_operand;
               end
            end
            S_RD_PTR:  r_ram_addr_hold <= r_addr;
            S_CAP_PTR: r_addr          <= bus.ram_rdata;
            S_RD_OP:   r_ram_addr_hold <= r_addr;
            S_CAP_OP:  r_op2           <= bus.ram_rdata;
            S_EXEC: begin
               r_acc             <= bus.alu_result;
               r_alu_opcode_hold <= r_op;
               r_alu_op1_hold    <= r_acc;
               r_alu_op2_hold    <= r_op2;
               r_alu_cin_hold    <= r_cy;
               if (w_arith) begin
                  r_cy <= bus.alu_cy;
                  r_ac <= bus.alu_ac;
                  r_ov <= bus.alu_ov;
               end
            end
            default: ;
         endcase
      end
   end

   // ALU and RAM address outputs are live only in their active states and hold otherwise.
   assign bus.req_ready    = w_ready;
   assign bus.ram_rd       = w_ram_rd;
   assign bus.ram_addr     = w_ram_rd ? r_addr : r_ram_addr_hold;
   assign bus.alu_opcode   = (r_state == S_EXEC) ? r_op  : r_alu_opcode_hold;
   assign bus.alu_op1      = (r_state == S_EXEC) ? r_acc : r_alu_op1_hold;
   assign bus.alu_op2      = (r_state == S_EXEC) ? r_op2 : r_alu_op2_hold;
   assign bus.alu_carry_in = (r_state == S_EXEC) ? r_cy  : r_alu_cin_hold;
   assign bus.acc_out      = r_acc;
   assign bus.psw_cy       = r_cy;
   assign bus.psw_ac       = r_ac;
   assign bus.psw_ov       = r_ov;
   assign bus.psw_p        = ^r_acc;
   assign bus.done         = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
//------------------------------------------------------------------------------
// tb_alu_operand_sequencer : directed bench with an ALU model and internal RAM model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_operand_sequencer;

   logic clock;
   logic reset;
   alu_operand_sequencer_if bus ();

   alu_operand_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [7:0] mem [0:255];

   always @(posedge clock) begin
      if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_addr];
   end

   // Reference 8051 ALU behaviour
   always_comb begin
      logic [8:0] w_sum;
      logic [4:0] w_nib;
      w_sum = 9'h000;
      w_nib = 5'h00;
      bus.alu_result = 8'h00;
      bus.alu_cy = 1'b0;
      bus.alu_ac = 1'b0;
      bus.alu_ov = 1'b0;
      case (bus.alu_opcode)
         3'b000: bus.alu_result = bus.alu_op1 + 8'd1;
         3'b001: bus.alu_result = bus.alu_op1 - 8'd1;
         3'b010, 3'b011: begin
            w_sum = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2}
                    + {8'h00, (bus.alu_opcode == 3'b011) & bus.alu_carry_in};
            w_nib = {1'b0, bus.alu_op1[3:0]} + {1'b0, bus.alu_op2[3:0]}
                    + {4'h0, (bus.alu_opcode == 3'b011) & bus.alu_carry_in};
            bus.alu_result = w_sum[7:0];
            bus.alu_cy = w_sum[8];
            bus.alu_ac = w_nib[4];
            bus.alu_ov = (bus.alu_op1[7] == bus.alu_op2[7]) && (w_sum[7] != bus.alu_op1[7]);
         end
         3'b100: begin
            w_sum = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2} - {8'h00, bus.alu_carry_in};
            w_nib = {1'b0, bus.alu_op1[3:0]} - {1'b0, bus.alu_op2[3:0]} - {4'h0, bus.alu_carry_in};
            bus.alu_result = w_sum[7:0];
            bus.alu_cy = w_sum[8];
            bus.alu_ac = w_nib[4];
            bus.alu_ov = (bus.alu_op1[7] != bus.alu_op2[7]) && (w_sum[7] != bus.alu_op1[7]);
         end
         3'b101: bus.alu_result = bus.alu_op1 | bus.alu_op2;
         3'b110: bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
         default: bus.alu_result = bus.alu_op1 & bus.alu_op2;
      endcase
   end

   int n_checks;
   int n_pass;
   int done_cyc;
   int rd_count;
   logic       cap_rd    [0:10];
   logic [7:0] cap_addr  [0:10];
   logic [7:0] cap_op1   [0:10];
   logic [7:0] cap_op2   [0:10];
   logic       cap_cin   [0:10];
   logic [7:0] cap_acc   [0:10];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load_acc(input logic [7:0] v);
      bus.acc_wr_en   = 1'b1;
      bus.acc_wr_data = v;
      step();
      bus.acc_wr_en   = 1'b0;
   endtask

   // Presents one request in cycle 0 and records ten following cycles.
   task automatic run_req(input logic [2:0] op, input logic [1:0] mode, input logic [7:0] opd,
                          input logic [1:0] rsel, input logic wr, input logic [7:0] wd);
      bus.req_valid   = 1'b1;
      bus.req_alu_op  = op;
      bus.req_mode    = mode;
      bus.req_operand = opd;
      bus.rs          = rsel;
      bus.acc_wr_en   = wr;
      bus.acc_wr_data = wd;
      done_cyc = 0;
      rd_count = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 1) begin
            bus.req_valid = 1'b0;
            bus.acc_wr_en = 1'b0;
         end
         cap_rd[c]   = bus.ram_rd;
         cap_addr[c] = bus.ram_addr;
         cap_op1[c]  = bus.alu_op1;
         cap_op2[c]  = bus.alu_op2;
         cap_cin[c]  = bus.alu_carry_in;
         cap_acc[c]  = bus.acc_out;
         if (bus.ram_rd) rd_count++;
         if (bus.done && done_cyc == 0) done_cyc = c;
      end
   endtask

   task automatic test_reset();
      n_checks++; if (bus.acc_out !== 8'h00) $display("FAIL rst_acc: got %h expected 00", bus.acc_out); else n_pass++;
      n_checks++; if ({bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p} !== 4'b0000)
         $display("FAIL rst_psw: got %b expected 0000", {bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p}); else n_pass++;
      n_checks++; if ({bus.ram_rd, bus.ram_addr} !== 9'h000)
         $display("FAIL rst_ram: got %h expected 000", {bus.ram_rd, bus.ram_addr}); else n_pass++;
      n_checks++; if ({bus.alu_opcode, bus.alu_op1, bus.alu_op2, bus.alu_carry_in} !== 20'h00000)
         $display("FAIL rst_alu: got %h expected 00000", {bus.alu_opcode, bus.alu_op1, bus.alu_op2, bus.alu_carry_in}); else n_pass++;
      n_checks++; if ({bus.done, bus.req_ready} !== 2'b00)
         $display("FAIL rst_done_ready: got %b expected 00", {bus.done, bus.req_ready}); else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", bus.req_ready); else n_pass++;
      step();
   endtask

   task automatic test_add_imm();
      load_acc(8'h3A);
      run_req(3'b010, 2'b00, 8'hC8, 2'b00, 1'b0, 8'h00);
      n_checks++; if (done_cyc !== 2) $display("FAIL add_done_cycle: got %0d expected 2", done_cyc); else n_pass++;
      n_checks++; if (cap_acc[2] !== 8'h02) $display("FAIL add_acc: got %h expected 02", cap_acc[2]); else n_pass++;
      n_checks++; if ({bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p} !== 4'b1101)
         $display("FAIL add_flags: got %b expected 1101", {bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p}); else n_pass++;
      n_checks++; if (rd_count !== 0) $display("FAIL add_no_ram: got %0d expected 0", rd_count); else n_pass++;
      n_checks++; if ({cap_op1[1], cap_op2[1]} !== 16'h3AC8)
         $display("FAIL add_operands: got %h expected 3ac8", {cap_op1[1], cap_op2[1]}); else n_pass++;
   endtask

   task automatic test_orl_direct();
      load_acc(8'hF0);
      run_req(3'b101, 2'b01, 8'h30, 2'b00, 1'b0, 8'h00);
      n_checks++; if ({cap_rd[1], cap_addr[1]} !== 9'h130)
         $display("FAIL orl_read: got %h expected 130", {cap_rd[1], cap_addr[1]}); else n_pass++;
      n_checks++; if (done_cyc !== 4) $display("FAIL orl_done_cycle: got %0d expected 4", done_cyc); else n_pass++;
      n_checks++; if (cap_acc[4] !== 8'hFF) $display("FAIL orl_acc: got %h expected ff", cap_acc[4]); else n_pass++;
      n_checks++; if ({bus.psw_cy, bus.psw_p} !== 2'b10)
         $display("FAIL orl_cy_p: got %b expected 10", {bus.psw_cy, bus.psw_p}); else n_pass++;
      n_checks++; if (cap_addr[5] !== 8'h30) $display("FAIL orl_addr_hold: got %h expected 30", cap_addr[5]); else n_pass++;
   endtask

   task automatic test_addc_reg();
      run_req(3'b011, 2'b10, 8'h05, 2'b10, 1'b0, 8'h00);
      n_checks++; if ({cap_rd[1], cap_addr[1]} !== 9'h115)
         $display("FAIL addc_read: got %h expected 115", {cap_rd[1], cap_addr[1]}); else n_pass++;
      n_checks++; if (cap_cin[3] !== 1'b1) $display("FAIL addc_carry_in: got %b expected 1", cap_cin[3]); else n_pass++;
      n_checks++; if (done_cyc !== 4) $display("FAIL addc_done_cycle: got %0d expected 4", done_cyc); else n_pass++;
      n_checks++; if ({bus.acc_out, bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p} !== 12'h20D)
         $display("FAIL addc_result: got %h expected 20d", {bus.acc_out, bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p}); else n_pass++;
   endtask

   task automatic test_subb_indirect();
      run_req(3'b100, 2'b11, 8'h01, 2'b01, 1'b0, 8'h00);
      n_checks++; if ({cap_rd[1], cap_addr[1]} !== 9'h109)
         $display("FAIL subb_ptr_read: got %h expected 109", {cap_rd[1], cap_addr[1]}); else n_pass++;
      n_checks++; if ({cap_rd[3], cap_addr[3]} !== 9'h140)
         $display("FAIL subb_op_read: got %h expected 140", {cap_rd[3], cap_addr[3]}); else n_pass++;
      n_checks++; if (rd_count !== 2) $display("FAIL subb_read_count: got %0d expected 2", rd_count); else n_pass++;
      n_checks++; if (cap_op2[5] !== 8'h11) $display("FAIL subb_op2: got %h expected 11", cap_op2[5]); else n_pass++;
      n_checks++; if (done_cyc !== 6) $display("FAIL subb_done_cycle: got %0d expected 6", done_cyc); else n_pass++;
      n_checks++; if ({bus.acc_out, bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p} !== 12'h0E5)
         $display("FAIL subb_result: got %h expected 0e5", {bus.acc_out, bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p}); else n_pass++;
   endtask

   task automatic test_inc_ignores_mode();
      load_acc(8'hFF);
      run_req(3'b000, 2'b01, 8'h30, 2'b00, 1'b0, 8'h00);
      n_checks++; if (rd_count !== 0) $display("FAIL inc_no_ram: got %0d expected 0", rd_count); else n_pass++;
      n_checks++; if (done_cyc !== 2) $display("FAIL inc_done_cycle: got %0d expected 2", done_cyc); else n_pass++;
      n_checks++; if ({bus.acc_out, bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p} !== 12'h004)
         $display("FAIL inc_result: got %h expected 004", {bus.acc_out, bus.psw_cy, bus.psw_ac, bus.psw_ov, bus.psw_p}); else n_pass++;
   endtask

   task automatic test_reset_abort();
      logic saw_done;
      saw_done = 1'b0;
      load_acc(8'h33);
      bus.req_valid   = 1'b1;
      bus.req_alu_op  = 3'b100;
      bus.req_mode    = 2'b11;
      bus.req_operand = 8'h01;
      bus.rs          = 2'b01;
      step();
      bus.req_valid = 1'b0;
      saw_done |= bus.done;
      step();
      saw_done |= bus.done;
      step();
      saw_done |= bus.done;
      reset = 1'b1;
      step();
      saw_done |= bus.done;
      n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL abort_ready_in_reset: got %b expected 0", bus.req_ready); else n_pass++;
      reset = 1'b0;
      step();
      n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL abort_ready_after: got %b expected 1", bus.req_ready); else n_pass++;
      n_checks++; if (bus.acc_out !== 8'h00) $display("FAIL abort_acc: got %h expected 00", bus.acc_out); else n_pass++;
      for (int c = 0; c < 6; c++) begin
         saw_done |= bus.done;
         step();
      end
      n_checks++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", saw_done); else n_pass++;
   endtask

   task automatic test_simultaneous_write();
      run_req(3'b010, 2'b00, 8'h01, 2'b00, 1'b1, 8'h05);
      n_checks++; if (cap_op1[1] !== 8'h05) $display("FAIL wr_alu_op1: got %h expected 05", cap_op1[1]); else n_pass++;
      n_checks++; if (bus.acc_out !== 8'h06) $display("FAIL wr_acc: got %h expected 06", bus.acc_out); else n_pass++;
      n_checks++; if (done_cyc !== 2) $display("FAIL wr_done_cycle: got %0d expected 2", done_cyc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] first_acc;
      load_acc(8'h0F);
      run_req(3'b110, 2'b00, 8'hFF, 2'b00, 1'b0, 8'h00);
      first_acc = bus.acc_out;
      run_req(3'b111, 2'b00, 8'h3C, 2'b00, 1'b0, 8'h00);
      n_checks++; if (first_acc !== 8'hF0) $display("FAIL b2b_xrl: got %h expected f0", first_acc); else n_pass++;
      n_checks++; if (bus.acc_out !== 8'h30) $display("FAIL b2b_anl: got %h expected 30", bus.acc_out); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      mem[8'h30] = 8'h0F;
      mem[8'h15] = 8'h20;
      mem[8'h09] = 8'h40;
      mem[8'h40] = 8'h11;
      reset = 1'b1;
      bus.req_valid   = 1'b0;
      bus.req_alu_op  = 3'b000;
      bus.req_mode    = 2'b00;
      bus.req_operand = 8'h00;
      bus.rs          = 2'b00;
      bus.acc_wr_en   = 1'b0;
      bus.acc_wr_data = 8'h00;
      repeat (3) step();
      test_reset();
      test_add_imm();
      test_orl_direct();
      test_addc_reg();
      test_subb_indirect();
      test_inc_ignores_mode();
      test_reset_abort();
      test_simultaneous_write();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
